// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst fill/check engine that drives a single-word memory
// request port. One accepted command becomes a run of back-to-back word
// transfers. Write phases store seed+i at start+i. Check phases read the same
// range back and count words that differ from the regenerated pattern.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_num,
  input  logic [WIDTH-1:0]      cmd_seed,
  // memory request port
  output logic                  wr_rd,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  // status
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [WIDTH-1:0]      first_err_data,
  output logic                  timeout,
  output logic                  cmd_err
);

  // Wide enough to hold the value TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b01;
  localparam logic [1:0] OP_WRCHK  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg;

  // Latched command fields.
  logic [1:0]              op_reg;
  logic [ADDR_WIDTH-1:0]   start_reg;
  logic [ADDR_WIDTH:0]     num_reg;
  logic [WIDTH-1:0]        seed_reg;

  // Burst progress: word index, pattern for that word, and ready wait count.
  logic [ADDR_WIDTH:0]     idx_reg;
  logic [WIDTH-1:0]        pat_reg;
  logic [TW-1:0]           wait_reg;

  // Registered outputs.
  logic                    cmd_ready_reg;
  logic                    wr_rd_reg;
  logic                    valid_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [WIDTH-1:0]        wdata_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [ADDR_WIDTH:0]     err_count_reg;
  logic [ADDR_WIDTH-1:0]   first_err_addr_reg;
  logic [WIDTH-1:0]        first_err_data_reg;
  logic                    timeout_reg;
  logic                    cmd_err_reg;

  // Derived per-cycle conditions.
  logic                    accept;
  logic                    handshake;
  logic                    last_word;
  logic                    wait_expired;
  logic                    mismatch;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [WIDTH-1:0]        pat_next;

  // Decode handshakes, end of burst, wait expiry and the next word's address.
  always_comb begin
    accept       = cmd_valid && cmd_ready_reg && (state_reg == IDLE);
    handshake    = valid_reg && ready;
    last_word    = ((idx_reg + (ADDR_WIDTH + 1)'(1)) == num_reg);
    wait_expired = (wait_reg == TW'(TIMEOUT - 1));
    mismatch     = (rdata != pat_reg);
    pat_next     = pat_reg + WIDTH'(1);
    // Addresses wrap modulo DEPTH, which need not be a power of two.
    if (addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
      addr_next = '0;
    end else begin
      addr_next = addr_reg + ADDR_WIDTH'(1);
    end
  end

  // Command FSM: acceptance, word sequencing, read checking, timeout and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      op_reg             <= OP_WRITE;
      start_reg          <= '0;
      num_reg            <= '0;
      seed_reg           <= '0;
      idx_reg            <= '0;
      pat_reg            <= '0;
      wait_reg           <= '0;
      cmd_ready_reg      <= 1'b1;
      wr_rd_reg          <= 1'b0;
      valid_reg          <= 1'b0;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      err_count_reg      <= '0;
      first_err_addr_reg <= '0;
      first_err_data_reg <= '0;
      timeout_reg        <= 1'b0;
      cmd_err_reg        <= 1'b0;
    end else begin
      // done is a single-cycle pulse; it is only set on the edge entering DONE.
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg             <= cmd_op;
            start_reg          <= cmd_addr;
            num_reg            <= cmd_num;
            seed_reg           <= cmd_seed;
            idx_reg            <= '0;
            pat_reg            <= cmd_seed;
            wait_reg           <= '0;
            err_count_reg      <= '0;
            first_err_addr_reg <= '0;
            first_err_data_reg <= '0;
            timeout_reg        <= 1'b0;
            cmd_err_reg        <= (cmd_op == OP_RSVD);
            cmd_ready_reg      <= 1'b0;
            busy_reg           <= 1'b1;
            if ((cmd_num == '0) || (cmd_op == OP_RSVD)) begin
              // Nothing to transfer: finish without ever raising valid.
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else if (cmd_op == OP_CHECK) begin
              state_reg <= RD;
              valid_reg <= 1'b1;
              wr_rd_reg <= 1'b0;
              addr_reg  <= cmd_addr;
              wdata_reg <= '0;
            end else begin
              // WRITE and WRITE_CHECK both begin with the write phase.
              state_reg <= WR;
              valid_reg <= 1'b1;
              wr_rd_reg <= 1'b1;
              addr_reg  <= cmd_addr;
              wdata_reg <= cmd_seed;
            end
          end
        end

        WR, RD: begin
          if (handshake) begin
            wait_reg <= '0;

            // Read data is only meaningful in the check phase.
            if ((state_reg == RD) && mismatch) begin
              err_count_reg <= err_count_reg + (ADDR_WIDTH + 1)'(1);
              if (err_count_reg == '0) begin
                first_err_addr_reg <= addr_reg;
                first_err_data_reg <= rdata;
              end
            end

            if (!last_word) begin
              // Present the next word immediately; valid stays high.
              idx_reg  <= idx_reg + (ADDR_WIDTH + 1)'(1);
              pat_reg  <= pat_next;
              addr_reg <= addr_next;
              if (state_reg == WR) begin
                wdata_reg <= pat_next;
              end
            end else if ((state_reg == WR) && (op_reg == OP_WRCHK)) begin
              // Switch to the check phase over the same range and seed.
              state_reg <= RD;
              idx_reg   <= '0;
              pat_reg   <= seed_reg;
              addr_reg  <= start_reg;
              wr_rd_reg <= 1'b0;
              wdata_reg <= '0;
            end else begin
              state_reg <= DONE;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else if (valid_reg) begin
            if (wait_expired) begin
              // Memory never answered: abandon the rest of the burst.
              state_reg   <= DONE;
              valid_reg   <= 1'b0;
              timeout_reg <= 1'b1;
              done_reg    <= 1'b1;
            end else begin
              wait_reg <= wait_reg + TW'(1);
            end
          end
        end

        DONE: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
          wr_rd_reg     <= 1'b0;
          wdata_reg     <= '0;
        end

        default: begin
          state_reg     <= IDLE;
          valid_reg     <= 1'b0;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_reg;
  assign wr_rd          = wr_rd_reg;
  assign valid          = valid_reg;
  assign addr           = addr_reg;
  assign wdata          = wdata_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err_count      = err_count_reg;
  assign first_err_addr = first_err_addr_reg;
  assign first_err_data = first_err_data_reg;
  assign timeout        = timeout_reg;
  assign cmd_err        = cmd_err_reg;

endmodule
